// File: rtl/dct_coef_buffer.sv
// dct_coef_buffer: ping-pong buffer capturing 64-word dct bursts and replaying sign-extended coefficients to the idct
module dct_coef_buffer #(
  parameter int DATA_W  = 32,
  parameter int COEF_HI = 31,
  parameter int COEF_LO = 16,
  parameter int BLK     = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_done,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_start,
  input  logic              out_reading,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        bank_count,
  output logic              overflow,
  output logic              short_block,
  output logic [1:0]        state_out
);
  localparam int CW = COEF_HI - COEF_LO + 1;
  localparam int AW = $clog2(BLK);
  localparam logic [AW-1:0] LAST = AW'(BLK - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, STREAM = 2'd1, SWITCH = 2'd2} state_t;

  logic [CW-1:0] mem_q [2][BLK];
  logic [AW-1:0] wcnt_q, rcnt_q;
  logic          wbank_q, rbank_q, blocked_q, overflow_q, short_q, out_start_q;
  logic [1:0]    valid_q, valid_d;
  logic [DATA_W-1:0] out_data_q;
  state_t        state_q;

  logic          wr_en, commit, consume;
  logic [CW-1:0] rd_word;
  logic          unused_in;

  assign unused_in = ^in_data;
  assign wr_en     = in_done && !blocked_q && !valid_q[wbank_q];
  assign commit    = wr_en && wcnt_q == LAST;
  assign consume   = state_q == STREAM && out_reading && rcnt_q == LAST;
  assign rd_word   = mem_q[rbank_q][rcnt_q];

  // Commit sets and consume clears always hit different banks, so they combine freely
  always_comb begin
    valid_d = (valid_q | {commit && wbank_q, commit && !wbank_q})
            & ~{consume && rbank_q, consume && !rbank_q};
  end

  // Coefficient storage; no reset needed since valid bits gate every read
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wbank_q][wcnt_q] <= in_data[COEF_HI:COEF_LO];
  end

  // Write side: capture, commit, drop after commit or when full, discard short bursts
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wcnt_q     <= '0;
      wbank_q    <= 1'b0;
      blocked_q  <= 1'b0;
      overflow_q <= 1'b0;
      short_q    <= 1'b0;
      valid_q    <= 2'b00;
    end else begin
      valid_q <= valid_d;
      short_q <= !in_done && wcnt_q != '0;
      if (!in_done) begin
        blocked_q <= 1'b0;
        wcnt_q    <= '0;
      end else if (!blocked_q) begin
        if (valid_q[wbank_q]) begin
          overflow_q <= 1'b1;
          blocked_q  <= 1'b1;
        end else if (wcnt_q == LAST) begin
          wcnt_q    <= '0;
          wbank_q   <= ~wbank_q;
          blocked_q <= 1'b1;
        end else begin
          wcnt_q <= wcnt_q + 1'b1;
        end
      end
    end
  end

  // Read FSM: wait for a committed bank, stream it on demand, then hand over to the other bank
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      rcnt_q      <= '0;
      rbank_q     <= 1'b0;
      out_start_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      unique case (state_q)
        IDLE: if (valid_q[rbank_q]) begin
          state_q     <= STREAM;
          out_start_q <= 1'b1;
        end
        STREAM: if (out_reading) begin
          out_data_q <= {{(DATA_W-CW){rd_word[CW-1]}}, rd_word};
          if (rcnt_q == LAST) begin
            rcnt_q  <= '0;
            rbank_q <= ~rbank_q;
            state_q <= SWITCH;
          end else begin
            rcnt_q <= rcnt_q + 1'b1;
          end
        end
        SWITCH: begin
          state_q     <= valid_q[rbank_q] ? STREAM : IDLE;
          out_start_q <= valid_q[rbank_q];
        end
        default: begin
          state_q     <= IDLE;
          out_start_q <= 1'b0;
        end
      endcase
    end
  end

  assign out_start   = out_start_q;
  assign out_data    = out_data_q;
  assign bank_count  = {1'b0, valid_q[0]} + {1'b0, valid_q[1]};
  assign overflow    = overflow_q;
  assign short_block = short_q;
  assign state_out   = state_q;
endmodule

// File: tb/tb_dct_coef_buffer.sv
// tb_dct_coef_buffer: directed and randomized bursts checked against a block-queue model of the buffer
module tb_dct_coef_buffer;
  logic        clk = 1'b0, reset = 1'b0, in_done = 1'b0, out_reading = 1'b0;
  logic [31:0] in_data = '0;
  logic        out_start, overflow, short_block;
  logic [31:0] out_data;
  logic [1:0]  bank_count, state_out;

  int          checks = 0, errors = 0;
  logic [31:0] expq[$];
  logic [31:0] bw[0:127];
  logic        ovf_m = 1'b0;

  dct_coef_buffer dut (
    .clk(clk), .reset(reset), .in_done(in_done), .in_data(in_data),
    .out_start(out_start), .out_reading(out_reading), .out_data(out_data),
    .bank_count(bank_count), .overflow(overflow), .short_block(short_block),
    .state_out(state_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] coef(input logic [31:0] w);
    logic signed [15:0] s;
    int v;
    s = w[31:16];
    v = s;
    return v;
  endfunction

  function automatic int nblk();
    return expq.size() / 64;
  endfunction

  task automatic fill_rand();
    for (int i = 0; i < 128; i++) bw[i] = $urandom;
  endtask

  task automatic burst(input int n);
    bit drop;
    drop = nblk() == 2;
    for (int i = 0; i < n; i++) begin
      in_done = 1'b1;
      in_data = bw[i];
      @(negedge clk);
    end
    in_done = 1'b0;
    in_data = $urandom;
    @(negedge clk);
    if (drop) ovf_m = 1'b1;
    else if (n >= 64) for (int i = 0; i < 64; i++) expq.push_back(bw[i]);
    chk("short_pulse", short_block, !drop && n < 64);
    chk("burst_count", bank_count, nblk());
    chk("burst_ovf", overflow, ovf_m);
    chk("burst_start", out_start, nblk() > 0);
    @(negedge clk);
    chk("short_clear", short_block, 0);
  endtask

  task automatic read_block(input bit gaps);
    logic [31:0] last;
    last = '0;
    for (int k = 0; k < 64; k++) begin
      if (gaps && k > 0 && $urandom_range(0, 3) == 0) begin
        out_reading = 1'b0;
        @(negedge clk);
        chk("hold_data", out_data, last);
      end
      out_reading = 1'b1;
      @(negedge clk);
      last = coef(expq.pop_front());
      chk("rd_data", out_data, last);
    end
    out_reading = 1'b0;
    chk("sw_state", state_out, 2);
    chk("sw_start", out_start, 1);
    @(negedge clk);
    chk("post_state", state_out, nblk() > 0 ? 1 : 0);
    chk("post_start", out_start, nblk() > 0);
    chk("post_count", bank_count, nblk());
  endtask

  initial begin
    #3;
    chk("rst_start", out_start, 0);
    chk("rst_data", out_data, 0);
    chk("rst_count", bank_count, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_short", short_block, 0);
    chk("rst_state", state_out, 0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    // one block of ramp coefficients
    for (int k = 0; k < 128; k++) bw[k] = k << 16;
    burst(64);
    chk("t1_state", state_out, 1);
    read_block(0);
    // sign extension of extreme coefficients
    fill_rand();
    bw[0] = 32'hFFFF0000;
    bw[1] = 32'h80000000;
    burst(64);
    chk("t2_w0", coef(expq[0]), 32'hFFFFFFFF);
    chk("t2_w1", coef(expq[1]), 32'hFFFF8000);
    read_block(1);
    // three bursts without reading: third is dropped, then back-to-back readout
    repeat (3) begin
      fill_rand();
      burst(64);
    end
    chk("t3_count", bank_count, 2);
    chk("t3_ovf", overflow, 1);
    read_block(1);
    read_block(0);
    // short burst
    fill_rand();
    burst(10);
    chk("t4_state", state_out, 0);
    // overlong burst keeps exactly 64, next burst captured normally
    fill_rand();
    burst(70);
    fill_rand();
    burst(64);
    chk("t5_count", bank_count, 2);
    read_block(1);
    read_block(1);
    // asynchronous reset in the middle of streaming
    fill_rand();
    burst(64);
    out_reading = 1'b1;
    repeat (20) begin
      @(negedge clk);
      chk("t6_data", out_data, coef(expq.pop_front()));
    end
    out_reading = 1'b0;
    #2 reset = 1'b0;
    #1;
    chk("t6_start", out_start, 0);
    chk("t6_data0", out_data, 0);
    chk("t6_count", bank_count, 0);
    chk("t6_state", state_out, 0);
    chk("t6_ovf", overflow, 0);
    @(negedge clk);
    reset = 1'b1;
    expq.delete();
    ovf_m = 1'b0;
    @(negedge clk);
    // randomized mix of burst kinds and reads
    repeat (16) begin
      int r;
      r = $urandom_range(0, 4);
      fill_rand();
      if (r <= 1) burst(64);
      else if (r == 2) burst($urandom_range(65, 100));
      else if (r == 3) burst($urandom_range(1, 63));
      if (nblk() > 0 && $urandom_range(0, 2) == 0) read_block(1);
    end
    while (nblk() > 0) read_block(1);
    chk("end_state", state_out, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
